lc3b_mem_responder: RTL
=======================

Name: lc3b_mem_responder

Overview:
- Memory-side responder for the LC-3b core's word-wide memory request interface.
- Accepts `mem_read`/`mem_write` requests from the core's control/datapath and services them from an internal word array after a programmable latency.
- Signals completion with a one-cycle `mem_resp` pulse.
- Used as the memory model in the core testbench and as on-chip RAM in synthesis.

Parameters:
- ADDR_W, 8: word-index width; array holds 2**ADDR_W 16-bit words.
- LATENCY, 2: number of BUSY cycles per transaction; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- mem_read  input  1  read request, held high until mem_resp
- mem_write  input  1  write request, held high until mem_resp
- mem_byte_enable  input  2  write lane enables; [1]=bits 15:8, [0]=bits 7:0
- mem_address  input  16  byte address; bit 0 ignored
- mem_wdata  input  16  write data
- mem_rdata  output  16  read data, registered
- mem_resp  output  1  transaction complete, one-cycle pulse

Behaviour:
- One clock (`clk`); reset is asynchronous and active-low (`reset_n`).
- Reset values: state=IDLE, count=0, mem_resp=0, mem_rdata=16'h0000, captured request cleared. Array contents are not reset.
- Word index = mem_address[ADDR_W:1]. Upper address bits are ignored, so addresses alias (wrap) modulo 2**(ADDR_W+1) bytes.
- FSM states:
  - IDLE:
    - If mem_read|mem_write at a clock edge: capture op, index, wdata, byte_enable; count<=LATENCY-1; go to BUSY.
    - Otherwise stay in IDLE.
  - BUSY:
    - If count!=0: count<=count-1.
    - If count==0: perform the op at this edge and go to RESP.
      - Read: mem_rdata<=array[index].
      - Write: update only the enabled byte lanes.
  - RESP: mem_resp=1 for exactly this cycle; next edge go to IDLE unconditionally.
- mem_resp is a registered decode of state==RESP and has no combinational path from the inputs.
- Timing: request first visible in cycle 0 gives mem_resp high in cycle LATENCY+1. Write data is visible to a following read.
- The mandatory IDLE cycle after RESP means back-to-back requests incur a one-cycle gap. A request still high during that IDLE cycle is treated as a new transaction.
- mem_rdata holds its last read value across writes and idle periods; it changes only on a read completion.
- Write with byte_enable=2'b00 completes normally (mem_resp pulses) and leaves the array unchanged.
- mem_read and mem_write both high at capture: treated as a write; mem_rdata is unchanged.
- Reset mid-transaction: return to IDLE immediately; any pending write is discarded; mem_resp drops asynchronously.
- Without the optional feature, inputs are ignored while in BUSY/RESP; the captured request completes even if the core deasserts early.

Optional Feature:
- Macro LC3B_MEM_ABORT_EN.
- Defined:
  - In BUSY, at each edge where both mem_read and mem_write are low, abort to IDLE.
  - No array write, no mem_rdata update, no mem_resp.
  - The abort check takes priority over count==0 completion.
- Undefined: no abort logic; behaviour as described in Behaviour.

Decomposition:
- Add to the shared lc3b_types package:
  - typedef lc3b_mem_be (logic [1:0]).
  - enum lc3b_mem_op {MEM_OP_READ, MEM_OP_WRITE}.
  - enum lc3b_mem_state {MEM_IDLE, MEM_BUSY, MEM_RESP}.
  - reuse lc3b_word.
- One sub-module, mem_array:
  - parameterised by ADDR_W;
  - synchronous write with two byte-lane enables;
  - read data registered at the edge on which `rd_en` is high.
- The FSM and latency counter stay in lc3b_mem_responder.

Test Plan:
- Reset then idle: reset_n low for 3 cycles with mem_read=1 → mem_resp=0, mem_rdata=16'h0000 throughout. After release, the first transaction starts normally.
- Write/read, LATENCY=2:
  - Write 16'hBEEF to address 16'h0010 with be=2'b11 → mem_resp in cycle 3.
  - Then read address 16'h0010 → mem_rdata=16'hBEEF in the mem_resp cycle.
- Byte lanes:
  - Preload 16'h1234 at 16'h0020; write 16'hAB00 with be=2'b10 → read returns 16'hAB34.
  - Then write 16'h00CD with be=2'b01 → read returns 16'hABCD.
- Aliasing/odd address, ADDR_W=8: write 16'h5A5A to 16'h0003 → read of 16'h0202 returns 16'h5A5A (same index 1).
- Mid-transaction reset: assert reset_n low during BUSY of a write of 16'hFFFF to 16'h0040 (previously 16'h0000) → no mem_resp; a later read returns 16'h0000.
- Early deassert in BUSY (read of 16'h0010 holding 16'hBEEF):
  - With LC3B_MEM_ABORT_EN: no mem_resp, mem_rdata unchanged.
  - Without it: mem_resp pulses at cycle LATENCY+1 and mem_rdata=16'hBEEF.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions: data word, memory byte enables,
// memory operation kind and memory responder FSM states.
package lc3b_types;

   typedef logic [15:0] lc3b_word;
   typedef logic [1:0]  lc3b_mem_be;

   typedef enum logic {
      MEM_OP_READ,
      MEM_OP_WRITE
   } lc3b_mem_op;

   typedef enum logic [1:0] {
      MEM_IDLE,
      MEM_BUSY,
      MEM_RESP
   } lc3b_mem_state;

   // Width of the latency down-counter; holds LATENCY-1 for LATENCY up to 15.
   localparam int MEM_CNT_W = 4;

endpackage

// File: rtl/mem_array.sv
// Word array built from two independent byte lanes so each lane maps onto
// its own block RAM with a synchronous write and a registered read.
module mem_array
   import lc3b_types::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr_en,
   input  logic [1:0]        wr_be,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] index,
   input  logic [15:0]       wr_data,
   output logic [15:0]       rd_data
);

   localparam int DEPTH = 2 ** ADDR_W;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_lane
         logic [7:0] lane_q [DEPTH];
         logic [7:0] rd_byte_q;

         // Lane write: only when this lane's byte enable is set.
         always_ff @(posedge clk) begin
            if (wr_en && wr_be[gi]) begin
               lane_q[index] <= wr_data[gi*8 +: 8];
            end
         end

         // Registered read; the output register is the only part that resets.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               rd_byte_q <= 8'h00;
            end else if (rd_en) begin
               rd_byte_q <= lane_q[index];
            end
         end

         assign rd_data[gi*8 +: 8] = rd_byte_q;
      end
   endgenerate

endmodule

// File: rtl/lc3b_mem_responder.sv
// LC-3b memory responder: captures a read/write request, waits LATENCY busy
// cycles, performs the access and pulses mem_resp for one cycle.
// Optional macro LC3B_MEM_ABORT_EN: dropping both requests while busy
// abandons the transaction without touching memory or mem_rdata.
module lc3b_mem_responder
   import lc3b_types::*;
#(
   parameter int ADDR_W  = 8,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  mem_byte_enable,
   input  logic [15:0] mem_address,
   input  logic [15:0] mem_wdata,
   output logic [15:0] mem_rdata,
   output logic        mem_resp
);

   lc3b_mem_state         state_q, state_d;
   logic [MEM_CNT_W-1:0]  count_q, count_d;
   lc3b_mem_op            op_q, op_d;
   logic [ADDR_W-1:0]     index_q, index_d;
   lc3b_word              wdata_q, wdata_d;
   lc3b_mem_be            be_q, be_d;
   logic                  resp_q;
   logic                  rd_en;
   logic                  wr_en;
   logic                  abort;

   // Upper address bits and the byte-select bit do not take part in indexing.
   logic unused_addr;
   assign unused_addr = ^{mem_address[15:ADDR_W+1], mem_address[0]};

`ifdef LC3B_MEM_ABORT_EN
   assign abort = ~mem_read & ~mem_write;
`else
   assign abort = 1'b0;
`endif

   // Next-state logic: capture in IDLE, count down in BUSY, single RESP cycle.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      op_d    = op_q;
      index_d = index_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      rd_en   = 1'b0;
      wr_en   = 1'b0;
      case (state_q)
         MEM_IDLE: begin
            if (mem_read || mem_write) begin
               // A simultaneous read and write is serviced as a write.
               op_d    = mem_write ? MEM_OP_WRITE : MEM_OP_READ;
               index_d = mem_address[ADDR_W:1];
               wdata_d = mem_wdata;
               be_d    = mem_byte_enable;
               count_d = MEM_CNT_W'(LATENCY - 1);
               state_d = MEM_BUSY;
            end
         end
         MEM_BUSY: begin
            if (abort) begin
               state_d = MEM_IDLE;
            end else if (count_q != '0) begin
               count_d = count_q - 1'b1;
            end else begin
               rd_en   = (op_q == MEM_OP_READ);
               wr_en   = (op_q == MEM_OP_WRITE);
               state_d = MEM_RESP;
            end
         end
         MEM_RESP: begin
            state_d = MEM_IDLE;
         end
         default: begin
            state_d = MEM_IDLE;
         end
      endcase
   end

   // State and captured-request registers; reset discards any pending request.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= MEM_IDLE;
         count_q <= '0;
         op_q    <= MEM_OP_READ;
         index_q <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         resp_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         op_q    <= op_d;
         index_q <= index_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         // Registered copy of "in RESP" so mem_resp has no path from inputs.
         resp_q  <= (state_d == MEM_RESP);
      end
   end

   assign mem_resp = resp_q;

   mem_array #(
      .ADDR_W (ADDR_W)
   ) u_mem_array (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (wr_en),
      .wr_be   (be_q),
      .rd_en   (rd_en),
      .index   (index_q),
      .wr_data (wdata_q),
      .rd_data (mem_rdata)
   );

endmodule
